// File: rtl/regs_wport_arb_pkg.sv
// Shared register-file definitions for the write-port arbiter: widths,
// requester count limits and the fixed writeback source indices.
package regs_wport_arb_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_NUM        = 32;
    localparam int NREQ_MAX       = 4;

    // Fixed requester slots on the write port.
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_MDU  = 2;
    localparam int WB_CP0  = 3;

    // Round-robin successor of idx among n requesters (wraps n-1 -> 0).
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regs_wport_arb_if.sv
// Write-port bus: per-requester valid/ready/addr/data plus the registered
// regfile write port. The arbiter uses the slave modport; the writeback
// sources and the register file together form the master side.
interface regs_wport_arb_if
    import regs_wport_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int DATA_W = REG_DATA_WIDTH
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we, waddr, wdata
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we, waddr, wdata
    );

endinterface

// File: rtl/regs_wport_arb_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping, and
// grants the first asserted request. The pointer moves past the winner
// and stays put when nothing is granted.
module rr_arbiter
    import regs_wport_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    // Pick the first requester at or after the pointer.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a
        // variable unassigned and no latch is inferred.
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        ptr_d       = ptr_q;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (!grant_vld_o && req_i[cand]) begin
                grant_vld_o   = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                ptr_d         = IDX_W'(rr_next(int'(cand), NREQ));
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of block ordering.
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regs_wport_arb.sv
// Register-file write-port arbiter. Shares one regfile write port between
// NREQ writeback sources with round-robin priority and a registered write
// stage. Writes to register 0 are acknowledged immediately and discarded.
// Optional feature: define WPORT_STATS_EN to count cycles in which two or
// more real (non-zero address) writes compete; otherwise conflict_cnt is 0.
module regs_wport_arb
    import regs_wport_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int DATA_W = REG_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    regs_wport_arb_if.slave bus,
    output logic [15:0]     conflict_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   addr_nz;
    logic [NREQ-1:0]   zero_req;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_vld;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Split requests into real writes and register-0 writes.
    always_comb begin
        addr_nz = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_nz[i] = |bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign zero_req = bus.req_valid & ~addr_nz;
    // A flush blocks arbitration for the cycle but register-0 drops still complete.
    assign elig     = bus.req_valid & addr_nz & {NREQ{~flush}};

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (elig),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    // Ready is held low while reset is asserted so nothing is acknowledged then.
    assign bus.req_ready = rst_n ? (zero_req | grant) : '0;

    // Select the granted write for the output stage; address/data hold when idle.
    always_comb begin
        we_d    = grant_vld;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_vld) begin
            waddr_d = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            wdata_d = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
        end
    end

    // Registered write stage feeding the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.we    = we_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;

`ifdef WPORT_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of cycles with two or more competing real writes.
    always_comb begin
        cnt_d = cnt_q;
        if (!flush && ($countones(bus.req_valid & addr_nz) >= 2) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Conflict counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regs_wport_arb.sv
// Directed bench for regs_wport_arb (NREQ=2). Stimulus pushes each expected
// regfile write into a queue; a monitor pops and compares whenever we=1.
// A small regfile model captures the writes for read-back checks.
module tb_regs_wport_arb;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    wr_t         exp_q[$];
    logic [31:0] rf [32];

    regs_wport_arb_if #(.NREQ(2), .ADDR_W(5), .DATA_W(32)) bus ();

    regs_wport_arb #(.NREQ(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Regfile model: takes whatever the write port presents.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) rf[r] <= 32'h0;
        end else if (bus.we) begin
            rf[bus.waddr] <= bus.wdata;
        end
    end

    // Monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(bus.waddr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("mon_waddr", 32'(bus.waddr), 32'(e.addr));
                check("mon_wdata", bus.wdata, e.data);
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
    endtask

    // Compare ready against the hand-computed vector and queue the expected write.
    task automatic ready_push(input string name, input logic [1:0] exp_rdy, input bit push,
                              input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        check(name, 32'(bus.req_ready), 32'(exp_rdy));
        if (push) begin
            w.addr = a;
            w.data = d;
            exp_q.push_back(w);
        end
    endtask

    // One cycle: check at the falling edge, then move to just after the next rising edge.
    task automatic step(input string name, input logic [1:0] exp_rdy, input bit push,
                        input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ready_push(name, exp_rdy, push, a, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. Async reset while a write is in flight and a request is pending.
        drive(2'b01, 5'd5, 32'h55, 5'd0, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_we",    32'(bus.we), 32'h0);
        check("rst_waddr", 32'(bus.waddr), 32'h0);
        check("rst_wdata", bus.wdata, 32'h0);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_cnt",   32'(conflict_cnt), 32'h0);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2. Single requester, back-to-back writes.
        drive(2'b01, 5'd5, 32'hA, 5'd0, 32'h0);
        step("t2_rdy_a", 2'b01, 1, 5'd5, 32'hA);
        drive(2'b01, 5'd6, 32'hB, 5'd0, 32'h0);
        step("t2_rdy_b", 2'b01, 1, 5'd6, 32'hB);
        drive(2'b01, 5'd7, 32'hC, 5'd0, 32'h0);
        step("t2_rdy_c", 2'b01, 1, 5'd7, 32'hC);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step("t2_idle", 2'b00, 0, 5'd0, 32'h0);
        @(negedge clk);
        check("t2_we_idle",    32'(bus.we), 32'h0);
        check("t2_waddr_hold", 32'(bus.waddr), 32'd7);
        check("t2_wdata_hold", bus.wdata, 32'hC);
        check("t2_r5", rf[5], 32'hA);
        check("t2_r6", rf[6], 32'hB);
        check("t2_r7", rf[7], 32'hC);
        @(posedge clk);
        #1;

        // Pointer is now 1; a lone req1 write returns it to 0.
        drive(2'b10, 5'd0, 32'h0, 5'd1, 32'h99);
        step("t3_pre", 2'b10, 1, 5'd1, 32'h99);

        // 3. Two real requests held, pointer 0: grant 0 then 1.
        drive(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
        step("t3_c0", 2'b01, 1, 5'd3, 32'h11);
        drive(2'b10, 5'd0, 32'h0, 5'd4, 32'h22);
        step("t3_c1", 2'b10, 1, 5'd4, 32'h22);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step("t3_idle", 2'b00, 0, 5'd0, 32'h0);
`ifdef WPORT_STATS_EN
        check("t3_cnt", 32'(conflict_cnt), 32'd1);
`else
        check("t3_cnt", 32'(conflict_cnt), 32'd0);
`endif

        // 4. Register-0 drop alongside a real write: both ready at once.
        drive(2'b11, 5'd9, 32'h909, 5'd0, 32'hDEAD);
        step("t4_both", 2'b11, 1, 5'd9, 32'h909);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step("t4_idle", 2'b00, 0, 5'd0, 32'h0);
        check("t4_r9", rf[9], 32'h909);
        check("t4_r0", rf[0], 32'h0);

        // 5. Flush blocks the real write; the register-0 drop still completes.
        flush = 1'b1;
        drive(2'b11, 5'd10, 32'h77, 5'd0, 32'hBEEF);
        step("t5_flush", 2'b10, 0, 5'd0, 32'h0);
        flush = 1'b0;
        drive(2'b01, 5'd10, 32'h77, 5'd0, 32'h0);
        @(negedge clk);
        check("t5_we_flushed", 32'(bus.we), 32'h0);
        check("t5_r10_keep", rf[10], 32'h0);
        ready_push("t5_retry", 2'b01, 1, 5'd10, 32'h77);
        @(posedge clk);
        #1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step("t5_idle", 2'b00, 0, 5'd0, 32'h0);
        check("t5_r10", rf[10], 32'h77);

        // 6. Same address from both, pointer 1: req1 lands first, req0 wins.
        drive(2'b11, 5'd8, 32'h1, 5'd8, 32'h2);
        step("t6_c0", 2'b10, 1, 5'd8, 32'h2);
        drive(2'b01, 5'd8, 32'h1, 5'd0, 32'h0);
        step("t6_c1", 2'b01, 1, 5'd8, 32'h1);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step("t6_idle0", 2'b00, 0, 5'd0, 32'h0);
        step("t6_idle1", 2'b00, 0, 5'd0, 32'h0);
        check("t6_r8", rf[8], 32'h1);
`ifdef WPORT_STATS_EN
        check("t6_cnt", 32'(conflict_cnt), 32'd2);
`else
        check("t6_cnt", 32'(conflict_cnt), 32'd0);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
